countdown_display: RTL and testbench



---
 rtl/countdown_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 78 +++++++
 rtl/countdown_display.sv | 134 +++++++++++++
 tb/tb_countdown_display.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared constants for the countdown display: widths, segment glyphs and the
// conversion FSM state type.
package countdown_pkg;

  localparam int TIME_W = 7;
  localparam int BCD_W  = 12;

  // Active-low glyphs, bit order g..a (bit 6 = g, bit 0 = a).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_D     = 7'h21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Decimal digit to glyph; non-decimal codes show nothing.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary to 3-digit BCD in
// one load cycle, seven shift cycles and one publish cycle.
//
// Handshake: start is only accepted while the FSM is in IDLE (state_o == IDLE);
// busy is high in SHIFT and DONE; done is a one-cycle pulse in DONE during
// which bcd holds the finished result. bcd is raw working state at all other
// times and must only be captured when done is high.
module bin2bcd_seq
  import countdown_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIME_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output conv_state_e       state_o
);

  localparam int SR_W = BCD_W + TIME_W;

  conv_state_e     state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;

  // Add 3 to every BCD nibble that is 5 or more; each nibble stays 4 bits.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Conversion FSM next state and shift-register datapath
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {dabble_adjust(sr_q[SR_W-1:TIME_W]), sr_q[TIME_W-1:0]} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bcd     = sr_q[SR_W-1:TIME_W];
  assign state_o = state_q;

endmodule

// File: rtl/countdown_display.sv
// Countdown display: samples the timer value, converts it to BCD and drives a
// 4-digit common-anode multiplexed display with blanking, warning blink and
// an "End" message once the timer has expired.
module countdown_display
  import countdown_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int WARN_THRESH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic              live,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              conv_busy,
  output logic [3:0]        an,
  output logic [7:0]        seg
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [9:0]         WARN_V    = 10'(WARN_THRESH);

  logic [TIME_W-1:0]  t_q;
  logic [TIME_W-1:0]  last_conv_q, last_conv_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic               conv_start;
  logic               conv_done;
  logic               conv_busy_w;
  logic [BCD_W-1:0]   conv_bcd;
  conv_state_e        conv_state;

  logic [3:0]         hund, tens, ones;
  logic [9:0]         bcd_val;
  logic [6:0]         glyph;
  logic               blank_win;

  // A new conversion starts only from IDLE, so a change that arrives mid-way
  // waits for the running conversion to publish first.
  assign conv_start = (conv_state == IDLE) && (t_q != last_conv_q);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (conv_start),
    .bin     (t_q),
    .busy    (conv_busy_w),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .state_o (conv_state)
  );

  assign hund    = bcd_out_q[11:8];
  assign tens    = bcd_out_q[7:4];
  assign ones    = bcd_out_q[3:0];
  assign bcd_val = 10'(hund) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);

  // Conversion bookkeeping plus the free-running scan and blink counters
  always_comb begin
    last_conv_d = last_conv_q;
    bcd_out_d   = bcd_out_q;
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_on_d  = blink_on_q;
    if (conv_start) last_conv_d = t_q;
    if (conv_done)  bcd_out_d   = conv_bcd;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  // Digit content, leading-zero blanking, warning blink and "End" message
  always_comb begin
    glyph = SEG_BLANK;
    case (digit_idx_q)
      2'd3: glyph = SEG_BLANK;
      2'd2: glyph = live ? ((hund == 4'd0) ? SEG_BLANK : seg_digit(hund)) : SEG_E;
      2'd1: glyph = live ? ((hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_digit(tens))
                         : SEG_N;
      default: glyph = live ? seg_digit(ones) : SEG_D;
    endcase
    // Zero while live is the hand-over second and deliberately stays steady.
    blank_win = live && (bcd_val >= 10'd1) && (bcd_val <= WARN_V) && !blink_on_q;
    an_d      = blank_win ? 4'b1111 : ~(4'b0001 << digit_idx_q);
    seg_d     = {1'b1, glyph};
  end

  // All top-level state; an and seg are registered together so they never skew
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q         <= '0;
      last_conv_q <= '0;
      bcd_out_q   <= '0;
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= 8'hFF;
    end else begin
      t_q         <= time_in;
      last_conv_q <= last_conv_d;
      bcd_out_q   <= bcd_out_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign conv_busy = conv_busy_w;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: directed scenarios plus random holds, with a
// scoreboard on published BCD values and a time-based display reference.
module tb_countdown_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;
  localparam int WARN  = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  time_in;
  logic        live;
  logic [11:0] bcd_out;
  logic        conv_busy;
  logic [3:0]  an;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  countdown_display #(
    .SCAN_DIV    (SCAN),
    .BLINK_DIV   (BLINK),
    .WARN_THRESH (WARN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_in   (time_in),
    .live      (live),
    .bcd_out   (bcd_out),
    .conv_busy (conv_busy),
    .an        (an),
    .seg       (seg)
  );

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  int          checks     = 0;
  int          passed     = 0;
  int          model_last = 0;
  int          cyc        = 0;
  int          change_cyc = -1;
  logic [11:0] prev_bcd   = 12'h000;

  // Edges since the last reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Active-low glyphs, g..a
  function automatic logic [6:0] glyph_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected display after edge e with steady value v and live flag lv
  task automatic exp_disp(input int v, input bit lv, input int e,
                          output logic [3:0] a, output logic [7:0] s);
    int idx, h, t, o;
    bit on;
    logic [6:0] g;
    idx = ((e - 1) / SCAN) % 4;
    on  = (((e - 1) / BLINK) % 2) == 0;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    g = 7'h7F;
    if (!lv) begin
      if (idx == 2) g = 7'h06;
      else if (idx == 1) g = 7'h2B;
      else if (idx == 0) g = 7'h21;
    end else begin
      if (idx == 2 && h != 0) g = glyph_of(h);
      else if (idx == 1 && (h != 0 || t != 0)) g = glyph_of(t);
      else if (idx == 0) g = glyph_of(o);
    end
    a = ~(4'b0001 << idx);
    if (lv && v >= 1 && v <= WARN && !on) a = 4'b1111;
    s = {1'b1, g};
  endtask

  // ---------------- monitor: every bcd_out change pops one expectation ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_bcd = 12'h000;
    end else if (bcd_out !== prev_bcd) begin
      if (exp_q.size() == 0) check("bcd_unexpected", bcd_out, prev_bcd);
      else                   check("bcd_out", bcd_out, exp_q.pop_front());
      prev_bcd   = bcd_out;
      change_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input int v);
    time_in = 7'(v);
    if (v != model_last) begin
      exp_q.push_back(to_bcd(v));
      model_last = v;
    end
  endtask

  task automatic settle();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() == 0) passed++;
    else begin
      $display("FAIL settle: %0d results pending after %0d cycles, expected 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic check_display(input int v, input bit lv, input int n);
    logic [3:0] a;
    logic [7:0] s;
    repeat (n) begin
      @(negedge clk);
      exp_disp(v, lv, cyc, a, s);
      check("an", an, a);
      if (a != 4'b1111) check("seg", seg, s);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt, rises, n, v;
    bit prev_busy, sent;
    bit lv;

    rst = 1'b1; time_in = 7'd0; live = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 8'hFF);
    check("rst_bcd", bcd_out, 12'h000);
    check("rst_busy", conv_busy, 1'b0);

    // 100: three digits, latency from release
    rst = 1'b0;
    apply(100);
    settle();
    check("latency", change_cyc, 10);
    check_display(100, 1'b1, 32);

    // 7: leading zeros blanked, blinking
    apply(7);
    settle();
    check_display(7, 1'b1, 48);

    // expired: "End", no blink
    live = 1'b0;
    apply(0);
    settle();
    check_display(0, 1'b0, 64);

    // change during a conversion: both values published in order
    live = 1'b1;
    apply(45);
    busy_cnt = 0; rises = 0; prev_busy = 1'b0; sent = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (conv_busy) busy_cnt++;
      if (conv_busy && !prev_busy) rises++;
      prev_busy = conv_busy;
      if (busy_cnt == 2 && !sent) begin
        apply(44);
        sent = 1'b1;
      end
    end
    check("busy_cycles", busy_cnt, 16);
    check("busy_rises", rises, 2);
    settle();
    check_display(44, 1'b1, 16);

    // reset in the middle of a conversion
    apply(127);
    n = 0;
    while (!conv_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", conv_busy, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", conv_busy, 1'b0);
    check("mid_rst_bcd", bcd_out, 12'h000);
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 8'hFF);
    exp_q.delete();
    model_last = 0;
    @(negedge clk);
    rst = 1'b0;
    apply(127);
    settle();
    check("bcd_127", bcd_out, 12'h127);
    check_display(127, 1'b1, 16);

    // threshold edge: 11 steady, 10 blinks
    apply(11);
    settle();
    check_display(11, 1'b1, 40);
    apply(10);
    settle();
    check_display(10, 1'b1, 40);

    // random holds
    repeat (10) begin
      v  = $urandom_range(0, 127);
      lv = 1'($urandom_range(0, 1));
      live = lv;
      apply(v);
      settle();
      check_display(v, lv, 20);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
